// File: rtl/parity_checker_multichannel_pkg.sv
// Shared definitions for the multi-channel parity checker.
//   DEFAULT_DATA_WIDTH / DEFAULT_CNT_WIDTH : default flit and error-counter widths
//   MAX_FLIT_WIDTH : widest flit the parity helper accepts
//   parity_ok()    : checks bit 0 of a zero-extended flit against the covered bits
//   clog2()        : ceiling log2, used for sizing counters at elaboration
package parity_checker_multichannel_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 4;
  localparam int MAX_FLIT_WIDTH     = 256;

  // The caller zero-extends the flit to MAX_FLIT_WIDTH. Zero padding does not
  // change an XOR reduction, so the actual flit width never has to be known here.
  function automatic logic parity_ok(input logic [MAX_FLIT_WIDTH-1:0] flit,
                                     input logic odd);
    logic expected;
    expected = (^flit[MAX_FLIT_WIDTH-1:1]) ^ odd;
    return (expected == flit[0]);
  endfunction

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/parity_checker_multichannel_monitor.sv
// One channel of the parity checker: parity check on consumed head flits,
// leaky-bucket error counter and sticky fault flags.
//   clk, reset       : clock, asynchronous active-low reset
//   flit             : head flit of this channel's FIFO (bit 0 = parity)
//   empty, read_en   : FIFO status / read strobe; a check happens on read of a non-empty FIFO
//   clear            : synchronous clear of counters and sticky flags
//   faulty           : one-cycle pulse per parity error
//   fault_sticky     : set on any error, held until clear/reset
//   link_faulty      : set once err_count reaches THRESHOLD, held until clear/reset
//   err_count        : current leaky-bucket error count
module parity_channel_monitor
  import parity_checker_multichannel_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ODD_PARITY    = 0,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int THRESHOLD     = 8,
  parameter int LEAK_INTERVAL = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] flit,
  input  logic                  empty,
  input  logic                  read_en,
  input  logic                  clear,
  output logic                  faulty,
  output logic                  fault_sticky,
  output logic                  link_faulty,
  output logic [CNT_WIDTH-1:0]  err_count
);

  localparam int GOOD_W = clog2(LEAK_INTERVAL + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [MAX_FLIT_WIDTH-1:0] flit_ext;
  logic                      check_event;
  logic                      error_event;

  logic                 faulty_reg, faulty_next;
  logic                 sticky_reg, sticky_next;
  logic                 link_reg,   link_next;
  logic [CNT_WIDTH-1:0] cnt_reg,    cnt_next;
  logic [GOOD_W-1:0]    good_reg,   good_next;

  logic [CNT_WIDTH-1:0] cnt_base;
  logic [GOOD_W-1:0]    good_base;
  logic [GOOD_W-1:0]    good_inc;

  always_comb begin
    flit_ext                   = '0;
    flit_ext[DATA_WIDTH-1:0]   = flit;
  end

  assign check_event = read_en && !empty;
  assign error_event = check_event && !parity_ok(flit_ext, 1'(ODD_PARITY));

  always_comb begin
    // Clear first, then any check event of the same cycle lands on the cleared state.
    cnt_base    = clear ? '0 : cnt_reg;
    good_base   = clear ? '0 : good_reg;
    good_inc    = good_base + GOOD_W'(1);
    sticky_next = clear ? 1'b0 : sticky_reg;
    link_next   = clear ? 1'b0 : link_reg;
    cnt_next    = cnt_base;
    good_next   = good_base;
    faulty_next = error_event;

    if (error_event) begin
      cnt_next    = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_WIDTH'(1);
      good_next   = '0;
      sticky_next = 1'b1;
      if (cnt_next >= CNT_WIDTH'(THRESHOLD)) begin
        link_next = 1'b1;
      end
    end else if (check_event) begin
      if (good_inc == GOOD_W'(LEAK_INTERVAL)) begin
        good_next = '0;
        cnt_next  = (cnt_base == '0) ? '0 : cnt_base - CNT_WIDTH'(1);
      end else begin
        good_next = good_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      faulty_reg <= 1'b0;
      sticky_reg <= 1'b0;
      link_reg   <= 1'b0;
      cnt_reg    <= '0;
      good_reg   <= '0;
    end else begin
      faulty_reg <= faulty_next;
      sticky_reg <= sticky_next;
      link_reg   <= link_next;
      cnt_reg    <= cnt_next;
      good_reg   <= good_next;
    end
  end

  assign faulty       = faulty_reg;
  assign fault_sticky = sticky_reg;
  assign link_faulty  = link_reg;
  assign err_count    = cnt_reg;

endmodule

// File: rtl/parity_checker_multichannel.sv
// Multi-channel registered parity checker with per-channel fault accounting.
//   clk, reset   : clock, asynchronous active-low reset
//   RX           : head flits, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   empty        : per-channel FIFO empty
//   read_en      : per-channel FIFO read strobe
//   clear        : per-channel synchronous clear of fault state
//   faulty       : per-channel one-cycle error pulse
//   fault_sticky : per-channel sticky error flag
//   link_faulty  : per-channel threshold-reached flag
//   err_count    : per-channel error count, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
module parity_checker_multichannel
  import parity_checker_multichannel_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_CH        = 5,
  parameter int ODD_PARITY    = 0,
  parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH,
  parameter int THRESHOLD     = 8,
  parameter int LEAK_INTERVAL = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] RX,
  input  logic [NUM_CH-1:0]           empty,
  input  logic [NUM_CH-1:0]           read_en,
  input  logic [NUM_CH-1:0]           clear,
  output logic [NUM_CH-1:0]           faulty,
  output logic [NUM_CH-1:0]           fault_sticky,
  output logic [NUM_CH-1:0]           link_faulty,
  output logic [NUM_CH*CNT_WIDTH-1:0] err_count
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      parity_channel_monitor #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ODD_PARITY    (ODD_PARITY),
        .CNT_WIDTH     (CNT_WIDTH),
        .THRESHOLD     (THRESHOLD),
        .LEAK_INTERVAL (LEAK_INTERVAL)
      ) u_monitor (
        .clk          (clk),
        .reset        (reset),
        .flit         (RX[gi*DATA_WIDTH +: DATA_WIDTH]),
        .empty        (empty[gi]),
        .read_en      (read_en[gi]),
        .clear        (clear[gi]),
        .faulty       (faulty[gi]),
        .fault_sticky (fault_sticky[gi]),
        .link_faulty  (link_faulty[gi]),
        .err_count    (err_count[gi*CNT_WIDTH +: CNT_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_parity_checker_multichannel.sv
module tb_parity_checker_multichannel;

  localparam int DW  = 32;
  localparam int NCH = 5;
  localparam int CW  = 4;

  localparam logic [DW-1:0] GOOD_FLIT = 32'h0000_0003; // bit0 = xor(bits31:1) = 1
  localparam logic [DW-1:0] BAD_FLIT  = 32'h0000_0002; // bit0 should be 1, is 0

  logic              clk;
  logic              reset;
  logic [NCH*DW-1:0] RX;
  logic [NCH-1:0]    empty, read_en, clear;
  logic [NCH-1:0]    faulty, fault_sticky, link_faulty;
  logic [NCH*CW-1:0] err_count;

  // Second instance: single odd-parity channel.
  logic [DW-1:0] rx_o;
  logic [0:0]    empty_o, read_en_o, clear_o;
  logic [0:0]    faulty_o, sticky_o, link_o;
  logic [CW-1:0] cnt_o;

  int n_cmp;
  int n_err;

  parity_checker_multichannel #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .ODD_PARITY(0), .CNT_WIDTH(CW),
    .THRESHOLD(8), .LEAK_INTERVAL(16)
  ) dut (
    .clk(clk), .reset(reset), .RX(RX), .empty(empty), .read_en(read_en),
    .clear(clear), .faulty(faulty), .fault_sticky(fault_sticky),
    .link_faulty(link_faulty), .err_count(err_count)
  );

  parity_checker_multichannel #(
    .DATA_WIDTH(DW), .NUM_CH(1), .ODD_PARITY(1), .CNT_WIDTH(CW),
    .THRESHOLD(8), .LEAK_INTERVAL(16)
  ) dut_odd (
    .clk(clk), .reset(reset), .RX(rx_o), .empty(empty_o), .read_en(read_en_o),
    .clear(clear_o), .faulty(faulty_o), .fault_sticky(sticky_o),
    .link_faulty(link_o), .err_count(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int ch);
    return err_count[ch*CW +: CW];
  endfunction

  task automatic set_rx(input int ch, input logic [DW-1:0] f);
    RX[ch*DW +: DW] = f;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    RX        = '0;
    for (int c = 0; c < NCH; c++) RX[c*DW +: DW] = GOOD_FLIT;
    empty     = '0;
    read_en   = '0;
    clear     = '0;
    rx_o      = GOOD_FLIT;
    empty_o   = '0;
    read_en_o = '0;
    clear_o   = '0;

    // Reset state
    #12;
    chk("reset_faulty", 32'(faulty), 32'h0);
    chk("reset_sticky", 32'(fault_sticky), 32'h0);
    chk("reset_link", 32'(link_faulty), 32'h0);
    chk("reset_count", 32'(err_count), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_release_count", 32'(err_count), 32'h0);
    $display("reset released, outputs idle");

    // 20 good flits on ch0
    set_rx(0, GOOD_FLIT);
    read_en = 5'b00001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ch0_good_faulty", 32'(faulty), 32'h0);
      chk("ch0_good_count", 32'(err_count), 32'h0);
    end
    read_en = '0;
    $display("ch0: 20 good flits, no faults");

    // Single bad flit on ch2
    set_rx(2, BAD_FLIT);
    read_en = 5'b00100;
    tick();
    chk("ch2_pulse", 32'(faulty), 32'h4);
    chk("ch2_sticky", 32'(fault_sticky), 32'h4);
    chk("ch2_count", 32'(cnt_of(2)), 32'd1);
    read_en = '0;
    tick();
    chk("ch2_pulse_end", 32'(faulty), 32'h0);
    chk("ch2_sticky_hold", 32'(fault_sticky), 32'h4);
    $display("ch2: one bad flit -> pulse, sticky, count 1");

    // Same bad flit while empty: ignored
    empty   = 5'b00100;
    read_en = 5'b00100;
    tick();
    chk("ch2_empty_faulty", 32'(faulty), 32'h0);
    chk("ch2_empty_count", 32'(cnt_of(2)), 32'd1);
    empty   = '0;
    read_en = '0;
    $display("ch2: read_en while empty ignored");

    // 8 back-to-back errors on ch1, then 16 good
    set_rx(1, BAD_FLIT);
    read_en = 5'b00010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("ch1_err_pulse", 32'(faulty[1]), 32'h1);
      chk("ch1_err_count", 32'(cnt_of(1)), 32'(i));
      chk("ch1_err_link", 32'(link_faulty[1]), (i >= 8) ? 32'h1 : 32'h0);
    end
    set_rx(1, GOOD_FLIT);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("ch1_leak_pulse", 32'(faulty[1]), 32'h0);
      chk("ch1_leak_count", 32'(cnt_of(1)), (i < 16) ? 32'd8 : 32'd7);
    end
    chk("ch1_link_hold", 32'(link_faulty[1]), 32'h1);
    read_en = '0;
    $display("ch1: 8 errors -> link_faulty, 16 good -> count 7, link held");

    // ch3: 3 errors then 64 good flits
    set_rx(3, BAD_FLIT);
    read_en = 5'b01000;
    for (int i = 0; i < 3; i++) tick();
    chk("ch3_count3", 32'(cnt_of(3)), 32'd3);
    set_rx(3, GOOD_FLIT);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("ch3_leak", 32'(cnt_of(3)), (k >= 48) ? 32'd0 : 32'(3 - k / 16));
    end
    chk("ch3_sticky_hold", 32'(fault_sticky[3]), 32'h1);
    chk("ch3_link_low", 32'(link_faulty[3]), 32'h0);
    read_en = '0;
    $display("ch3: count 3->2->1->0 and holds at 0");

    // ch4: 20 errors saturate at 15
    set_rx(4, BAD_FLIT);
    read_en = 5'b10000;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("ch4_sat", 32'(cnt_of(4)), (i > 15) ? 32'd15 : 32'(i));
    end
    chk("ch4_link", 32'(link_faulty[4]), 32'h1);
    // Clear plus error in the same cycle
    clear = 5'b10000;
    tick();
    chk("ch4_clr_count", 32'(cnt_of(4)), 32'd1);
    chk("ch4_clr_sticky", 32'(fault_sticky[4]), 32'h1);
    chk("ch4_clr_link", 32'(link_faulty[4]), 32'h0);
    chk("ch4_clr_pulse", 32'(faulty[4]), 32'h1);
    clear   = '0;
    read_en = '0;
    tick();
    chk("ch4_clr_hold", 32'(cnt_of(4)), 32'd1);
    $display("ch4: saturate at 15, clear+error -> count 1");

    // Odd-parity instance
    rx_o      = GOOD_FLIT;
    read_en_o = 1'b1;
    tick();
    chk("odd_0x3_flagged", 32'(faulty_o), 32'h1);
    chk("odd_0x3_count", 32'(cnt_o), 32'd1);
    rx_o = 32'h0000_0002;
    tick();
    chk("odd_0x2_ok", 32'(faulty_o), 32'h0);
    chk("odd_0x2_count", 32'(cnt_o), 32'd1);
    read_en_o = 1'b0;
    $display("odd parity: 0x3 flagged, 0x2 accepted");

    // Asynchronous reset mid-stream
    set_rx(0, BAD_FLIT);
    read_en = 5'b00001;
    tick();
    chk("pre_reset_pulse", 32'(faulty[0]), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_faulty", 32'(faulty), 32'h0);
    chk("async_sticky", 32'(fault_sticky), 32'h0);
    chk("async_link", 32'(link_faulty), 32'h0);
    chk("async_count", 32'(err_count), 32'h0);
    chk("async_odd_count", 32'(cnt_o), 32'h0);
    read_en = '0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("after_reset_count", 32'(err_count), 32'h0);
    chk("after_reset_sticky", 32'(fault_sticky), 32'h0);
    $display("async reset mid-stream clears all state");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
